// File: rtl/cache_port_arbiter_if.sv
// rtl/cache_port_arbiter_if.sv - requester and next-level bus bundle for cache_port_arbiter
interface cache_port_arbiter_if #(
  parameter int NREQ     = 2,
  parameter int ADDRBITS = 32,
  parameter int LINEBITS = 2048
);
  localparam int GW = $clog2(NREQ);

  logic [NREQ-1:0]          req_request;
  logic [NREQ-1:0]          req_write;
  logic [NREQ*ADDRBITS-1:0] req_addr;
  logic [NREQ*LINEBITS-1:0] req_wdata;
  logic [NREQ-1:0]          req_valid;
  logic [LINEBITS-1:0]      req_rdata;
  logic [NREQ-1:0]          req_error;
  logic                     nl_request;
  logic                     nl_write;
  logic [ADDRBITS-1:0]      nl_addr;
  logic [LINEBITS-1:0]      nl_wdata;
  logic                     nl_valid;
  logic [LINEBITS-1:0]      nl_rdata;
  logic                     busy;
  logic [GW-1:0]            grant_id;

  modport slave (
    input  req_request, req_write, req_addr, req_wdata, nl_valid, nl_rdata,
    output req_valid, req_rdata, req_error, nl_request, nl_write, nl_addr, nl_wdata,
           busy, grant_id
  );

  modport master (
    output req_request, req_write, req_addr, req_wdata, nl_valid, nl_rdata,
    input  req_valid, req_rdata, req_error, nl_request, nl_write, nl_addr, nl_wdata,
           busy, grant_id
  );
endinterface

// File: rtl/cache_port_arbiter.sv
// rtl/cache_port_arbiter.sv - round-robin share of one next-level cache port, one transaction in flight
// Optional watchdog enabled by defining CACHE_ARB_TIMEOUT_EN.
module cache_port_arbiter #(
  parameter int NREQ     = 2,
  parameter int ADDRBITS = 32,
  parameter int LINEBITS = 2048,
  parameter int TIMEOUT  = 1024
) (
  input  logic                 clock,
  input  logic                 reset,
  cache_port_arbiter_if.slave  bus
);
  localparam int GW = $clog2(NREQ);
  localparam int SW = GW + 2;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESPOND, S_ERROR} state_t;

  state_t              r_state, w_next;
  logic [GW-1:0]       r_last, r_grant, w_pick;
  logic                r_write;
  logic [ADDRBITS-1:0] r_addr;
  logic [LINEBITS-1:0] r_wdata, r_rdata;
  logic                w_found, w_expire;
  logic [GW:0]         w_shamt;
  logic [NREQ-1:0]     w_rot;
  logic [SW-1:0]       w_sum;
  logic                w_sel_write;
  logic [ADDRBITS-1:0] w_sel_addr;
  logic [LINEBITS-1:0] w_sel_wdata;

  // Rotate so bit j is requester (last+1+j) mod NREQ; the lowest set bit wins.
  assign w_shamt = {1'b0, r_last} + (GW+1)'(1);
  assign w_rot   = NREQ'({bus.req_request, bus.req_request} >> w_shamt);

  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_sum   = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (!w_found && w_rot[j]) begin
        w_found = 1'b1;
        w_sum   = SW'(r_last) + SW'(j + 1);
        if (w_sum >= SW'(NREQ)) w_sum = w_sum - SW'(NREQ);
        w_pick  = GW'(w_sum);
      end
    end
  end

  always_comb begin
    w_sel_write = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick == GW'(i)) begin
        w_sel_write = bus.req_write[i];
        w_sel_addr  = bus.req_addr[i*ADDRBITS +: ADDRBITS];
        w_sel_wdata = bus.req_wdata[i*LINEBITS +: LINEBITS];
      end
    end
  end

`ifdef CACHE_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                  r_cnt <= '0;
    else if (r_state == S_ISSUE) r_cnt <= '0;
    else if (r_state == S_WAIT)  r_cnt <= r_cnt + CW'(1);
  end

  // Last WAIT cycle before the limit; a same-cycle nl_valid still takes priority.
  assign w_expire = (r_state == S_WAIT) && (r_cnt == CW'(TIMEOUT - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
  assign w_expire         = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_found) w_next = S_ISSUE;
      S_ISSUE:   w_next = S_WAIT;
      S_WAIT: begin
        if (bus.nl_valid)  w_next = S_RESPOND;
        else if (w_expire) w_next = S_ERROR;
      end
      S_RESPOND: w_next = S_IDLE;
      S_ERROR:   w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_last  <= GW'(NREQ - 1);
      r_grant <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (r_state == S_IDLE && w_found) begin
        r_grant <= w_pick;
        r_write <= w_sel_write;
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
      end
      if (r_state == S_WAIT && bus.nl_valid) r_rdata <= bus.nl_rdata;
      if (r_state == S_RESPOND || r_state == S_ERROR) r_last <= r_grant;
    end
  end

  assign bus.nl_request = (r_state == S_ISSUE);
  assign bus.nl_write   = r_write;
  assign bus.nl_addr    = r_addr;
  assign bus.nl_wdata   = r_wdata;
  assign bus.req_rdata  = r_rdata;
  assign bus.req_valid  = (r_state == S_RESPOND) ? (NREQ'(1) << r_grant) : '0;
  assign bus.req_error  = (r_state == S_ERROR)   ? (NREQ'(1) << r_grant) : '0;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.grant_id   = r_grant;
endmodule
